sub_shift_mix: RTL and testbench
================================

// Module: sub_shift_mix
// PURPOSE
//   One AES-128 encryption round datapath ahead of the round-key stage: SubBytes -> ShiftRows -> MixColumns.
//   Feeds the round-key XOR stage of the same round, in an unrolled chain of 10 rounds.
//   Round 10 bypasses MixColumns. Registered output, valid/ready handshake with backpressure.
//   State is 128 bits [0:127], byte 0 = bits [0:7], column-major (bytes 0-3 = column 0).
// PARAMETERS
//   RND_W   4   width of the round-number tag (rounds 1..10 legal)
// PORTS
//   clk        in   1        rising-edge clock, single domain
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        input beat valid
//   in_ready   out  1        block can accept a beat this cycle
//   in_rnd     in   RND_W    round number of the input beat
//   data_in    in   128      state after the previous AddRoundKey
//   out_valid  out  1        output beat valid
//   out_ready  in   1        downstream accepts the beat
//   out_rnd    out  RND_W    round tag carried with the beat
//   data_out   out  128      transformed state
//   rnd_err    out  1        sticky: an illegal round number was accepted
// BEHAVIOUR
//   - Reset (rst=1 at posedge): out_valid=0, data_out=0, out_rnd=0, rnd_err=0, all pipeline valids cleared;
//     beats in flight are discarded. in_ready=1 in the cycle after reset.
//   - Accept on in_valid&in_ready; emit on out_valid&out_ready. Latency: 1 clk from accept to out_valid.
//   - Each stage register loads when it is empty or its content is leaving the same cycle;
//     in_ready = !out_valid | out_ready (combinational path from out_ready, by design).
//   - Full throughput: one beat per clk while out_ready=1. out_ready=0 holds data_out/out_rnd stable.
//   - SubBytes: FIPS-197 S-box on all 16 bytes. ShiftRows: row r (byte index mod 4 = r) rotated left r columns.
//   - MixColumns over GF(2^8), poly 0x11B: b0=2a0^3a1^a2^a3, etc. xtime(x)=(x<<1)^(x[7]?0x1B:0).
//   - in_rnd==10: MixColumns skipped, output = ShiftRows(SubBytes(data_in)).
//   - in_rnd==0 or >10: beat accepted and dropped (no out_valid), rnd_err set until rst.
//   - Simultaneous accept+emit on a full stage: new beat replaces old, no bubble, no loss.
//   - in_valid with in_ready=0: upstream must hold data_in/in_rnd; unconsumed beats are not sampled.
// CONFIGURATION
//   SSM_SBOX_PIPE_EN defined: extra register stage after SubBytes; latency 2 clk, throughput unchanged
//     (per-stage valid and same load rule; in_ready depends on stage-1 occupancy and downstream readiness).
//   Not defined: SubBytes/ShiftRows/MixColumns combinational in one stage, latency 1 clk.
//   rnd_err / drop behaviour identical in both builds (drop decided at accept).
// STRUCTURE
//   Package aes_pkg: 256-entry S-box constant table, xtime and gf_mul3 functions,
//     AES_NUM_RND=10, AES_BLK_W=128, round-tag typedef.
//   Sub-module aes_sbox (8-bit in -> 8-bit out, combinational), instantiated 16x.
//   ShiftRows/MixColumns as package functions; no further sub-modules.
// TESTING
//   1 rnd=1, data_in=193de3bea0f4e22b9ac68d2ae9f84808 -> data_out=046681e5e0cb199a48f8d37a2806264c, out_rnd=1, 1 clk later.
//   2 rnd=10, data_in=0100..00 -> 7c636363_63636363_63636363_63636363; rnd=1 same input -> 5d7c7c42_63..63.
//   3 Back-to-back 8 beats rnd 1..8, out_ready=1 -> 8 outputs consecutive cycles, order and tags preserved.
//   4 out_ready=0 for 5 clk with beats offered -> in_ready=0 after stage fills, data_out stable; release -> no loss/dup.
//   5 rnd=0 then rnd=11 -> no out_valid, rnd_err=1 sticky; next legal beat processed normally.
//   6 rst asserted with beat in flight -> out_valid=0 next clk, rnd_err=0, data_out=0; repeat 1-4 with SSM_SBOX_PIPE_EN (latency 2).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES round helpers: S-box table, GF(2^8) arithmetic, ShiftRows and MixColumns.
// Byte i of a block is bits [127-8i -: 8], so byte 0 is the most significant byte.
package aes_pkg;

  localparam int AES_NUM_RND = 10;
  localparam int AES_BLK_W   = 128;
  localparam int AES_RND_W   = 4;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [AES_RND_W-1:0] aes_rnd_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] get_byte(input aes_blk_t s, input int i);
    aes_blk_t t;
    t = s >> (8 * (15 - i));
    return t[7:0];
  endfunction

  // Assumes the target byte of s is still zero.
  function automatic aes_blk_t or_byte(input aes_blk_t s, input int i, input logic [7:0] b);
    return s | (aes_blk_t'(b) << (8 * (15 - i)));
  endfunction

  // Row r (byte index mod 4) rotates left by r columns.
  function automatic aes_blk_t shift_rows(input aes_blk_t s);
    aes_blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o = or_byte(o, 4 * c + r, get_byte(s, 4 * ((c + r) % 4) + r));
      end
    end
    return o;
  endfunction

  function automatic aes_blk_t mix_columns(input aes_blk_t s);
    aes_blk_t   o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4 * c);
      a1 = get_byte(s, 4 * c + 1);
      a2 = get_byte(s, 4 * c + 2);
      a3 = get_byte(s, 4 * c + 3);
      o = or_byte(o, 4 * c,     xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3);
      o = or_byte(o, 4 * c + 1, a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3);
      o = or_byte(o, 4 * c + 2, a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3));
      o = or_byte(o, 4 * c + 3, gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3));
    end
    return o;
  endfunction

  // Final round has no MixColumns.
  function automatic aes_blk_t round_out(input aes_blk_t sub, input logic last);
    aes_blk_t sr;
    sr = shift_rows(sub);
    return last ? sr : mix_columns(sr);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/sub_shift_mix.sv
// AES encryption round front half: SubBytes -> ShiftRows -> MixColumns (skipped on round 10).
// Optional macro SSM_SBOX_PIPE_EN adds a register after SubBytes (latency 2 instead of 1).
module sub_shift_mix
  import aes_pkg::*;
#(
  parameter int RND_W = AES_RND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RND_W-1:0] in_rnd,
  input  logic [127:0]     data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RND_W-1:0] out_rnd,
  output logic [127:0]     data_out,
  output logic             rnd_err
);

  logic             out_vld_q, out_vld_d;
  logic [RND_W-1:0] out_rnd_q, out_rnd_d;
  aes_blk_t         out_data_q, out_data_d;
  logic             err_q, err_d;

  aes_blk_t sub_w;
  logic     accept;
  logic     rnd_ok;
  logic     out_free;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (data_in[127-8*i -: 8]),
      .dout (sub_w[127-8*i -: 8])
    );
  end

  // Illegal rounds are still accepted (upstream must not stall), just never forwarded.
  assign rnd_ok   = (in_rnd != '0) && (int'(in_rnd) <= AES_NUM_RND);
  assign out_free = !out_vld_q || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef SSM_SBOX_PIPE_EN
  logic             s1_vld_q, s1_vld_d;
  logic [RND_W-1:0] s1_rnd_q, s1_rnd_d;
  aes_blk_t         s1_data_q, s1_data_d;
  logic             s1_move;

  assign s1_move  = s1_vld_q && out_free;
  assign in_ready = !s1_vld_q || out_free;
`else
  assign in_ready = out_free;
`endif

  always_comb begin
    // NOTE: every _d is given its hold value first so no branch can leave it unassigned and infer a latch.
    out_vld_d  = out_vld_q;
    out_rnd_d  = out_rnd_q;
    out_data_d = out_data_q;
    err_d      = err_q || (accept && !rnd_ok);
`ifdef SSM_SBOX_PIPE_EN
    s1_vld_d  = s1_vld_q;
    s1_rnd_d  = s1_rnd_q;
    s1_data_d = s1_data_q;
    if (accept) begin
      s1_vld_d = rnd_ok;
      if (rnd_ok) begin
        s1_rnd_d  = in_rnd;
        s1_data_d = sub_w;
      end
    end else if (s1_move) begin
      s1_vld_d = 1'b0;
    end
    if (s1_move) begin
      out_vld_d  = 1'b1;
      out_rnd_d  = s1_rnd_q;
      out_data_d = round_out(s1_data_q, int'(s1_rnd_q) == AES_NUM_RND);
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
`else
    if (accept) begin
      out_vld_d = rnd_ok;
      if (rnd_ok) begin
        out_rnd_d  = in_rnd;
        out_data_d = round_out(sub_w, int'(in_rnd) == AES_NUM_RND);
      end
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_rnd_q  <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
`ifdef SSM_SBOX_PIPE_EN
      s1_vld_q   <= 1'b0;
      s1_rnd_q   <= '0;
      s1_data_q  <= '0;
`endif
    end else begin
      out_vld_q  <= out_vld_d;
      out_rnd_q  <= out_rnd_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
`ifdef SSM_SBOX_PIPE_EN
      s1_vld_q   <= s1_vld_d;
      s1_rnd_q   <= s1_rnd_d;
      s1_data_q  <= s1_data_d;
`endif
    end
  end

  assign out_valid = out_vld_q;
  assign out_rnd   = out_rnd_q;
  assign data_out  = out_data_q;
  assign rnd_err   = err_q;

endmodule

// File: tb/tb_sub_shift_mix.sv
// Directed self-checking bench for sub_shift_mix; latency follows SSM_SBOX_PIPE_EN.
module tb_sub_shift_mix;

`ifdef SSM_SBOX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [127:0] VA    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VA1   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] VA10  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] VB    = 128'h01000000000000000000000000000000;
  localparam logic [127:0] VB1   = 128'h5d7c7c42636363636363636363636363;
  localparam logic [127:0] VB10  = 128'h7c636363636363636363636363636363;
  localparam logic [127:0] VR2   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] VR2M  = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;
  localparam logic [127:0] VZ    = 128'h0;
  localparam logic [127:0] VZM   = {16{8'h63}};
  localparam logic [127:0] V52   = {16{8'h52}};
  localparam logic [127:0] VFF   = {16{8'hff}};
  localparam logic [127:0] VFFM  = {16{8'h16}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, rnd_err;
  logic [3:0]   in_rnd, out_rnd;
  logic [127:0] data_in, data_out;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   rnd;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        mon_b;
  int           checks = 0;
  int           failures = 0;
  int           cycle = 0;

  logic [127:0] vec_in [8];
  logic [127:0] vec_out[8];

  sub_shift_mix #(.RND_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rnd    (in_rnd),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rnd   (out_rnd),
    .data_out  (data_out),
    .rnd_err   (rnd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output scoreboard: every emitted beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL mon_extra_beat: observed data_out=%h rnd=%0d expected no beat", data_out, out_rnd);
      end
      if (exp_q.size() != 0) begin
        mon_b = exp_q.pop_front();
        chk("mon_data", data_out, mon_b.data);
        chk("mon_rnd", 128'(out_rnd), 128'(mon_b.rnd));
      end
    end
  end

  // Offer one beat and hold it until accepted; inputs change 1 time unit after a posedge.
  task automatic send(input logic [127:0] d, input logic [3:0] r, input logic [127:0] e, input bit legal);
    bit    done;
    beat_t b;
    done     = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    in_rnd   = r;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (legal) begin
          b.data = e;
          b.rnd  = r;
          exp_q.push_back(b);
        end
      end
      @(posedge clk);
      #1;
    end
    chk("send_accepted", 128'(done), 128'(1));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    data_in  = '0;
    in_rnd   = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_idle_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held_data;
    logic [3:0]   held_rnd;
    int           start, k, acc;

    vec_in  = '{VA,  VB,  VZ,  V52, VFF,  VR2,  VA,  VB};
    vec_out = '{VA1, VB1, VZM, VZ,  VFFM, VR2M, VA1, VB1};

    rst = 1'b1; in_valid = 1'b0; in_rnd = '0; data_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    chk("rst_out_rnd", 128'(out_rnd), 128'(0));
    chk("rst_rnd_err", 128'(rnd_err), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 round 1 vector with latency check
    send(VA, 4'd1, VA1, 1'b1);
    idle();
    repeat (LAT - 1) begin @(posedge clk); #1; end
    chk("t1_valid", 128'(out_valid), 128'(1));
    chk("t1_data", data_out, VA1);
    chk("t1_rnd", 128'(out_rnd), 128'(1));
    drain();

    // Final round skips MixColumns; same input with mixing
    send(VB, 4'd10, VB10, 1'b1);
    idle();
    drain();
    send(VB, 4'd1, VB1, 1'b1);
    send(VA, 4'd10, VA10, 1'b1);
    idle();
    drain();

    // Back-to-back beats, rounds 1..8
    start = cycle;
    for (int i = 0; i < 8; i++) send(vec_in[i], 4'(i + 1), vec_out[i], 1'b1);
    idle();
    chk("b2b_accept_cycles", 128'(cycle - start), 128'(8));
    drain();

    // Backpressure: out_ready low for 5 cycles with beats offered
    out_ready = 1'b0;
    k = 0; acc = 0;
    held_data = '0; held_rnd = '0;
    in_valid = 1'b1; data_in = vec_in[0]; in_rnd = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) begin
        mon_b.data = vec_out[k];
        mon_b.rnd  = 4'(k + 1);
        exp_q.push_back(mon_b);
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc > k) begin
        k++;
        data_in = vec_in[k];
        in_rnd  = 4'(k + 1);
      end
      if (i == 2) begin
        held_data = data_out;
        held_rnd  = out_rnd;
      end
    end
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    chk("stall_valid", 128'(out_valid), 128'(1));
    chk("stall_data_stable", data_out, held_data);
    chk("stall_rnd_stable", 128'(out_rnd), 128'(held_rnd));
    chk("stall_data_first", data_out, vec_out[0]);
    chk("stall_accepted", 128'(acc), 128'(LAT));
    out_ready = 1'b1;
    for (int i = k; i < 4; i++) send(vec_in[i], 4'(i + 1), vec_out[i], 1'b1);
    idle();
    drain();

    // Illegal rounds are dropped and set a sticky error
    send(VZ, 4'd0, VZ, 1'b0);
    send(VZ, 4'd11, VZ, 1'b0);
    idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("err_set", 128'(rnd_err), 128'(1));
    chk("err_no_valid", 128'(out_valid), 128'(0));
    send(VR2, 4'd2, VR2M, 1'b1);
    idle();
    drain();
    chk("err_sticky", 128'(rnd_err), 128'(1));

    // Reset with a beat in flight
    out_ready = 1'b0;
    send(VA, 4'd1, VA1, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_valid", 128'(out_valid), 128'(0));
    chk("rst2_data", data_out, 128'(0));
    chk("rst2_rnd", 128'(out_rnd), 128'(0));
    chk("rst2_err", 128'(rnd_err), 128'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst2_in_ready", 128'(in_ready), 128'(1));
    repeat (3) begin @(posedge clk); #1; end
    chk("rst2_flushed", 128'(out_valid), 128'(0));
    send(VB, 4'd10, VB10, 1'b1);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
